// File: rtl/txn_timeout_guard.sv
// In-line latency guard for one AXI address channel with snooped responses.
// Optional perf counters (max_lat_o, fault_cnt_o) under TXN_TIMEOUT_GUARD_PERF_EN.
module txn_timeout_guard #(
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned MaxTxns  = 8,
  parameter int unsigned CntWidth = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         guard_ena_i,
  input  logic [CntWidth-1:0]          budget_i,
  input  logic                         clear_i,
  input  logic                         mst_req_valid_i,
  output logic                         mst_req_ready_o,
  output logic                         slv_req_valid_o,
  input  logic                         slv_req_ready_i,
  input  logic [IdWidth-1:0]           req_id_i,
  input  logic                         rsp_valid_i,
  input  logic                         rsp_ready_i,
  input  logic                         rsp_last_i,
  input  logic [IdWidth-1:0]           rsp_id_i,
  output logic [$clog2(MaxTxns+1)-1:0] outstanding_o,
  output logic                         irq_o,
  output logic                         rst_req_o,
  output logic [1:0]                   fault_cause_o,
  output logic [IdWidth-1:0]           fault_id_o
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
  ,
  output logic [CntWidth-1:0]          max_lat_o,
  output logic [7:0]                   fault_cnt_o
`endif
);

  localparam int unsigned OutW = $clog2(MaxTxns + 1);
  localparam int unsigned IdxW = $clog2(MaxTxns);

  typedef enum logic [1:0] {StRun, StFault, StFlush} state_e;

  state_e                state;
  logic [MaxTxns-1:0]    valid;
  logic [IdWidth-1:0]    ids [MaxTxns];
  logic [CntWidth-1:0]   cnt [MaxTxns];

  logic                  full;
  logic                  ok;
  logic                  alloc;
  logic [IdxW-1:0]       alloc_idx;
  logic                  beat;
  logic                  hit;
  logic [IdxW-1:0]       hit_idx;
  logic [CntWidth-1:0]   hit_cnt;
  logic                  retire;
  logic                  to_any;
  logic [IdWidth-1:0]    to_id;
  logic                  to_fault;
  logic                  unexp;

  assign full            = &valid;
  assign ok              = !guard_ena_i || (state == StRun && !full);
  assign slv_req_valid_o = mst_req_valid_i & ok;
  assign mst_req_ready_o = slv_req_ready_i & ok;
  assign alloc           = guard_ena_i & mst_req_valid_i & slv_req_ready_i & ok;
  assign beat            = rsp_valid_i & rsp_ready_i & rsp_last_i;
  assign retire          = beat & hit & (state == StRun);
  assign unexp           = beat & !hit & guard_ena_i & (state == StRun);
  assign to_fault        = guard_ena_i && (budget_i != '0) && (state == StRun) && to_any;

  always_comb begin
    alloc_idx = '0;
    for (int i = int'(MaxTxns) - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IdxW'(i);
    end
  end

  // Oldest match: strictly larger counter wins, so ties keep the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_cnt = '0;
    for (int i = 0; i < int'(MaxTxns); i++) begin
      if (valid[i] && ids[i] == rsp_id_i && (!hit || cnt[i] > hit_cnt)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
        hit_cnt = cnt[i];
      end
    end
  end

  // An entry retired this cycle cannot time out.
  always_comb begin
    to_any = 1'b0;
    to_id  = '0;
    for (int i = int'(MaxTxns) - 1; i >= 0; i--) begin
      if (valid[i] && cnt[i] >= budget_i && !(retire && hit_idx == IdxW'(i))) begin
        to_any = 1'b1;
        to_id  = ids[i];
      end
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < int'(MaxTxns); i++) begin
      if (valid[i]) outstanding_o = outstanding_o + OutW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= StRun;
      valid         <= '0;
      irq_o         <= 1'b0;
      rst_req_o     <= 1'b0;
      fault_cause_o <= 2'b00;
      fault_id_o    <= '0;
      for (int i = 0; i < int'(MaxTxns); i++) begin
        ids[i] <= '0;
        cnt[i] <= '0;
      end
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
      max_lat_o   <= '0;
      fault_cnt_o <= '0;
`endif
    end else begin
      unique case (state)
        StRun: begin
          for (int i = 0; i < int'(MaxTxns); i++) begin
            if (valid[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CntWidth'(1);
          end
          if (retire) valid[hit_idx] <= 1'b0;
          if (alloc) begin
            valid[alloc_idx] <= 1'b1;
            ids[alloc_idx]   <= req_id_i;
            cnt[alloc_idx]   <= '0;
          end
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
          if (retire && hit_cnt > max_lat_o) max_lat_o <= hit_cnt;
`endif
          if (to_fault || unexp) begin
            state         <= StFault;
            irq_o         <= 1'b1;
            rst_req_o     <= 1'b1;
            fault_cause_o <= to_fault ? 2'b01 : 2'b10;
            fault_id_o    <= to_fault ? to_id : rsp_id_i;
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
            if (fault_cnt_o != 8'hff) fault_cnt_o <= fault_cnt_o + 8'd1;
`endif
          end
        end
        StFault: begin
          if (clear_i) begin
            state         <= StFlush;
            valid         <= '0;
            irq_o         <= 1'b0;
            rst_req_o     <= 1'b0;
            fault_cause_o <= 2'b00;
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
            max_lat_o     <= '0;
`endif
          end
        end
        StFlush: begin
          state <= StRun;
          valid <= '0;
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
          max_lat_o <= '0;
`endif
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_txn_timeout_guard.sv
// Directed plus randomized bench for txn_timeout_guard against a slot-table reference model.
module tb_txn_timeout_guard;

  localparam int IdW  = 4;
  localparam int Max  = 8;
  localparam int CntW = 10;
  localparam int Sat  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst, en, clear, mst_valid, slv_ready, rsp_valid, rsp_ready, rsp_last;
  logic [CntW-1:0] budget;
  logic [IdW-1:0]  req_id, rsp_id;
  logic            mst_ready, slv_valid, irq, rst_req;
  logic [3:0]      outstanding;
  logic [1:0]      cause;
  logic [IdW-1:0]  fid;
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
  logic [CntW-1:0] max_lat;
  logic [7:0]      fault_cnt;
`endif

  always #5 clk = ~clk;

  txn_timeout_guard dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .guard_ena_i     (en),
    .budget_i        (budget),
    .clear_i         (clear),
    .mst_req_valid_i (mst_valid),
    .mst_req_ready_o (mst_ready),
    .slv_req_valid_o (slv_valid),
    .slv_req_ready_i (slv_ready),
    .req_id_i        (req_id),
    .rsp_valid_i     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_last_i      (rsp_last),
    .rsp_id_i        (rsp_id),
    .outstanding_o   (outstanding),
    .irq_o           (irq),
    .rst_req_o       (rst_req),
    .fault_cause_o   (cause),
    .fault_id_o      (fid)
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
    ,
    .max_lat_o       (max_lat),
    .fault_cnt_o     (fault_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: slots with ID and age; mode 0 = run, 1 = fault, 2 = flush.
  bit m_valid [Max];
  int m_id    [Max];
  int m_age   [Max];
  int m_mode, m_irq, m_cause, m_fid, m_maxlat, m_fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < Max; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Max; i++) begin
      m_valid[i] = 0;
      m_age[i]   = 0;
      m_id[i]    = 0;
    end
    m_mode = 0; m_irq = 0; m_cause = 0; m_fid = 0; m_maxlat = 0; m_fcnt = 0;
  endtask

  task automatic model_step();
    int hidx, toidx, aidx;
    bit ok, do_alloc, beat;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == 1) begin
      if (clear) begin
        m_mode = 2; m_irq = 0; m_cause = 0; m_maxlat = 0;
        for (int i = 0; i < Max; i++) m_valid[i] = 0;
      end
      return;
    end
    if (m_mode == 2) begin
      m_mode = 0; m_maxlat = 0;
      for (int i = 0; i < Max; i++) m_valid[i] = 0;
      return;
    end
    ok       = !en || (m_count() < Max);
    do_alloc = en && mst_valid && slv_ready && ok;
    beat     = rsp_valid && rsp_ready && rsp_last;
    hidx = -1;
    if (beat)
      for (int i = 0; i < Max; i++)
        if (m_valid[i] && m_id[i] == int'(rsp_id) && (hidx < 0 || m_age[i] > m_age[hidx]))
          hidx = i;
    toidx = -1;
    if (en && budget != 0)
      for (int i = Max - 1; i >= 0; i--)
        if (m_valid[i] && m_age[i] >= int'(budget) && i != hidx) toidx = i;
    aidx = -1;
    for (int i = Max - 1; i >= 0; i--) if (!m_valid[i]) aidx = i;
    if (toidx >= 0 || (beat && hidx < 0 && en)) begin
      m_mode = 1; m_irq = 1;
      m_cause = (toidx >= 0) ? 1 : 2;
      m_fid   = (toidx >= 0) ? m_id[toidx] : int'(rsp_id);
      if (m_fcnt < 255) m_fcnt++;
    end
    if (hidx >= 0 && m_age[hidx] > m_maxlat) m_maxlat = m_age[hidx];
    for (int i = 0; i < Max; i++) if (m_valid[i] && m_age[i] < Sat) m_age[i]++;
    if (hidx >= 0) m_valid[hidx] = 0;
    if (do_alloc) begin
      m_valid[aidx] = 1;
      m_id[aidx]    = int'(req_id);
      m_age[aidx]   = 0;
    end
  endtask

  task automatic check_all();
    bit ok;
    ok = !en || (m_mode == 0 && m_count() < Max);
    chk("slv_valid", 32'(slv_valid), 32'(mst_valid && ok));
    chk("mst_ready", 32'(mst_ready), 32'(slv_ready && ok));
    chk("outstanding", 32'(outstanding), 32'(m_count()));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rst_req", 32'(rst_req), 32'(m_irq));
    chk("cause", 32'(cause), 32'(m_cause));
    chk("fault_id", 32'(fid), 32'(m_fid));
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
    chk("max_lat", 32'(max_lat), 32'(m_maxlat));
    chk("fault_cnt", 32'(fault_cnt), 32'(m_fcnt));
`endif
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; clear = 0; mst_valid = 0; rsp_valid = 0; rsp_last = 0;
  endtask

  task automatic respond(input int id);
    rsp_valid = 1; rsp_last = 1; rsp_id = IdW'(id);
  endtask

  int q[$];
  int n;

  initial begin
    rst = 1; en = 1; clear = 0; mst_valid = 0; slv_ready = 1; rsp_valid = 0; rsp_ready = 1;
    rsp_last = 0; budget = 20; req_id = 0; rsp_id = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    tick();
    quiet();
    chk("reset_outstanding", 32'(outstanding), 0);
    chk("reset_irq", 32'(irq), 0);

    // Baseline: ID 3 answered with latency 5.
    mst_valid = 1; req_id = 3; tick(); quiet();
    chk("base_out1", 32'(outstanding), 1);
    repeat (5) tick();
    respond(3); tick(); quiet();
    chk("base_out0", 32'(outstanding), 0);
    chk("base_irq", 32'(irq), 0);
`ifdef TXN_TIMEOUT_GUARD_PERF_EN
    chk("base_maxlat", 32'(max_lat), 5);
`endif

    // Fill, then stall while full even with a same-cycle retire.
    budget = 0;
    for (int i = 0; i < Max; i++) begin
      mst_valid = 1; req_id = IdW'(i); tick();
    end
    #1 chk("full_ready", 32'(mst_ready), 0);
    chk("full_valid", 32'(slv_valid), 0);
    respond(0); req_id = 9; tick(); rsp_valid = 0;
    #1 chk("after_retire_ready", 32'(mst_ready), 1);
    tick(); quiet();
    chk("refill_out", 32'(outstanding), 8);
    rst = 1; tick(); quiet();

    // Timeout on ID 5, then clear.
    budget = 10; mst_valid = 1; req_id = 5; tick(); quiet();
    n = 0;
    while (irq !== 1'b1 && n < 30) begin tick(); n++; end
    chk("to_wait", 32'(n), 11);
    chk("to_cause", 32'(cause), 1);
    chk("to_id", 32'(fid), 5);
    chk("to_rstreq", 32'(rst_req), 1);
    clear = 1; tick(); clear = 0;
    chk("flush_irq", 32'(irq), 0);
    chk("flush_out", 32'(outstanding), 0);
    tick();

    // Same-ID ordering.
    budget = 0;
    mst_valid = 1; req_id = 2; tick(); quiet();
    repeat (2) tick();
    mst_valid = 1; req_id = 2; tick(); quiet();
    tick();
    respond(2); tick(); quiet();
    chk("sameid_out", 32'(outstanding), 1);
    repeat (3) tick();
    rst = 1; tick(); quiet();

    // Unexpected response, then blocked requests.
    respond(7); tick(); quiet();
    chk("unexp_cause", 32'(cause), 2);
    chk("unexp_id", 32'(fid), 7);
    mst_valid = 1;
    #1 chk("fault_block", 32'(slv_valid), 0);
    tick(); quiet();
    clear = 1; tick(); quiet(); tick();

    // Response in the exact cycle the counter reaches the budget.
    budget = 10; mst_valid = 1; req_id = 1; tick(); quiet();
    repeat (10) tick();
    respond(1); tick(); quiet();
    repeat (2) tick();
    chk("race_irq", 32'(irq), 0);
    en = 0; respond(9); tick(); quiet(); tick();
    chk("dis_irq", 32'(irq), 0);
    en = 1; respond(4); tick(); quiet(); tick();
    chk("rstfault_pre", 32'(irq), 1);
    rst = 1; tick(); quiet();
    chk("rstfault_irq", 32'(irq), 0);
    chk("rstfault_cause", 32'(cause), 0);
    chk("rstfault_id", 32'(fid), 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) begin
        n = $urandom_range(0, 5);
        budget = (n == 0) ? CntW'(0) : CntW'($urandom_range(4, 60));
      end
      rst       = ($urandom_range(0, 499) == 0);
      en        = ($urandom_range(0, 9) != 0);
      mst_valid = $urandom_range(0, 1);
      slv_ready = ($urandom_range(0, 9) < 7);
      req_id    = IdW'($urandom_range(0, 3));
      rsp_valid = ($urandom_range(0, 9) < 3);
      rsp_ready = ($urandom_range(0, 9) < 8);
      rsp_last  = ($urandom_range(0, 9) < 7);
      q.delete();
      for (int i = 0; i < Max; i++) if (m_valid[i]) q.push_back(m_id[i]);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        rsp_id = IdW'(q[$urandom_range(0, q.size() - 1)]);
      else
        rsp_id = IdW'($urandom_range(0, 15));
      clear = (m_mode == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/txn_timeout_guard.md
Name: txn_timeout_guard

Overview:
- Parametrised, channel-agnostic successor to the per-direction read/write guards.
- Sits in-line on one AXI address channel (AW or AR) and passively snoops the matching response channel (B or R).
- Tracks up to MaxTxns outstanding transactions in a table, with a latency counter per entry.
- Flags a fault on a budget overrun or an unmatched response, then blocks new requests until software clears it.
- Two instances (write, read) replace the fixed-function guards under the top-level guard wrapper.

Parameters:
IdWidth, 4, width of the transaction ID carried on request and response.
MaxTxns, 8, table depth (maximum outstanding transactions); must be >= 2.
CntWidth, 10, latency counter and budget width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
guard_ena_i  in  1  1 = tracking and fault detection active; 0 = transparent pass-through
budget_i  in  CntWidth  latency budget in cycles; 0 disables timeout detection
clear_i  in  1  software fault acknowledge, single-cycle pulse
mst_req_valid_i  in  1  request valid from manager
mst_req_ready_o  out  1  request ready to manager
slv_req_valid_o  out  1  request valid to subordinate
slv_req_ready_i  in  1  request ready from subordinate
req_id_i  in  IdWidth  ID of the current request
rsp_valid_i  in  1  snooped response valid
rsp_ready_i  in  1  snooped response ready
rsp_last_i  in  1  last beat of the response (tie to 1 for B)
rsp_id_i  in  IdWidth  response ID
outstanding_o  out  $clog2(MaxTxns+1)  number of valid table entries
irq_o  out  1  fault interrupt, level
rst_req_o  out  1  subordinate reset request, level
fault_cause_o  out  2  01 = timeout, 10 = unexpected response, 00 = none
fault_id_o  out  IdWidth  ID of the faulting transaction

Behaviour:
- Reset values: all entries invalid, state RUN, outstanding_o=0, irq_o=0, rst_req_o=0, fault_cause_o=0, fault_id_o=0.
- Request gating (combinational, zero latency):
  - ok = !guard_ena_i | (state==RUN & !full).
  - slv_req_valid_o = mst_req_valid_i & ok.
  - mst_req_ready_o = slv_req_ready_i & ok.
- Allocation:
  - Occurs on the request handshake while guard_ena_i=1.
  - Uses the lowest free index; stores the ID and loads the entry counter with 0.
  - full = all entries valid.
  - Full is evaluated on registered state only; an entry freed by a retire is reusable from the next cycle, with no bypass.
- Counters:
  - Each valid entry increments by 1 every cycle.
  - Counters saturate at all-ones and never wrap.
- Retire:
  - Occurs on rsp_valid_i & rsp_ready_i & rsp_last_i.
  - Frees the oldest valid entry whose ID equals rsp_id_i.
  - Oldest = largest counter; ties go to the lowest index.
  - Non-last beats are ignored.
- Simultaneous allocation and retire in one cycle: both take effect; outstanding_o is unchanged.
- Timeout:
  - Detected in a cycle where guard_ena_i=1, budget_i!=0, and some valid entry has counter >= budget_i.
  - An entry retired in that same cycle does not count; the retire wins.
  - With several candidates, the lowest-index entry supplies fault_id_o.
- Unexpected response: a last-beat handshake with no matching valid entry while guard_ena_i=1 and state==RUN.
- Both fault types in one cycle: timeout has priority.
- State machine:
  - RUN -> FAULT on a detected fault. The transition is registered: irq_o, rst_req_o, fault_cause_o and fault_id_o update in the cycle after detection.
  - FAULT: irq_o=1 and rst_req_o=1. Requests are blocked (ok=0 if enabled). Responses, timeouts and counters are ignored; the table is frozen. clear_i -> FLUSH.
  - FLUSH (1 cycle): all entries invalidated, irq_o=0, rst_req_o=0, fault_cause_o=0. fault_id_o holds its value. -> RUN.
  - clear_i is ignored in RUN and FLUSH.
- guard_ena_i=0:
  - No allocation, no fault detection.
  - Existing entries still count and retire, so outstanding_o drains.
  - A FAULT state persists until clear_i regardless of enable.
- rst_i mid-operation: returns to reset values next edge; in-flight table contents are lost.

Optional Feature:
- Macro: TXN_TIMEOUT_GUARD_PERF_EN.
- Defined:
  - Adds output max_lat_o [CntWidth], reset 0.
  - On each retire, max_lat_o updates next cycle to max(max_lat_o, retired entry counter).
  - Cleared to 0 in FLUSH.
  - Also adds output fault_cnt_o [8]: increments on each RUN->FAULT transition, saturates at 255, and is cleared only by rst_i.
- Undefined: both outputs and their logic are absent; all other behaviour is identical.

Test Plan:
- Baseline, budget_i=20, enable=1: issue ID 3, respond (last) 5 cycles later -> no irq, outstanding_o 1->0, max_lat_o=5 (perf build).
- Fill the table: 8 requests back-to-back with slv ready=1 -> the 9th request sees mst_req_ready_o=0 and slv_req_valid_o=0. A retire plus a new request in the same cycle -> the request is stalled that cycle and accepted the next.
- Timeout, budget_i=10: issue ID 5 and never respond -> irq_o=1, rst_req_o=1, fault_cause_o=01, fault_id_o=5 in the cycle after the counter reaches 10. Pulse clear_i -> FLUSH, then RUN, outstanding_o=0.
- Same-ID ordering: two requests with ID 2, 3 cycles apart, then one last beat for ID 2 -> the older entry is retired and the younger keeps counting.
- Unexpected response: response ID 7 with nothing outstanding -> fault_cause_o=10, fault_id_o=7. Requests are blocked while in FAULT.
- Simultaneous events: a response arrives in the exact cycle the counter hits budget_i -> retire, no fault. guard_ena_i=0 with an orphan response -> no fault. rst_i asserted in FAULT -> all outputs return to reset values.
